sd_req_arbiter: RTL and testbench

- Shares the single SD-card block interface (lba, rd/wr strobes, ack, 512-byte buffer port) between NUM_REQ floppy track-buffer loaders, e.g. two 1541 drives, or a drive plus a cartridge/tape image loader.
- Sits between the IO-controller SD port and the per-drive track loaders.
- Grants one transaction at a time in round-robin order.
- Steers the ack and buffer-write signals to the granted requester only.
- Aborts a request that gets no ack within TIMEOUT cycles.

---
 rtl/sd_req_arbiter_if.sv | 33 +++
 rtl/sd_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_sd_req_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_req_arbiter_if.sv
// Bundle between the SD block port, the per-drive track loaders and the arbiter.
// The arbiter takes the master modport; the loaders/IO controller side takes slave.
interface sd_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [32*NUM_REQ-1:0] req_lba;
  logic [NUM_REQ-1:0]    req_rd;
  logic [NUM_REQ-1:0]    req_wr;
  logic [8*NUM_REQ-1:0]  req_buff_din;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    req_buff_wr;
  logic [NUM_REQ-1:0]    req_timeout;
  logic [NUM_REQ-1:0]    grant;
  logic [31:0]           sd_lba;
  logic                  sd_rd;
  logic                  sd_wr;
  logic                  sd_ack;
  logic                  sd_buff_wr;
  logic [7:0]            sd_buff_din;
  logic                  busy;

  modport master (
    input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, req_timeout, grant, sd_lba, sd_rd, sd_wr,
           sd_buff_din, busy
  );

  modport slave (
    output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, req_timeout, grant, sd_lba, sd_rd, sd_wr,
           sd_buff_din, busy
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin owner of the single SD block port: one 512-byte block per grant,
// ack/buffer strobes steered to the owner, stalled requests aborted after TIMEOUT.
module sd_req_arbiter #(
  parameter int          NUM_REQ = 2,
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic              clk,
  input  logic              reset_n,
  sd_req_arbiter_if.master  bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_XFER, S_RELEASE} state_t;

  state_t             r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n;
  logic [NUM_REQ-1:0] r_timeout, w_timeout_n;
  logic [31:0]        r_lba, w_lba_n;
  logic               r_rd, w_rd_n, r_wr, w_wr_n;
  logic [IW-1:0]      r_last, w_last_n, r_sel, w_sel_n;
  logic [23:0]        r_cnt, w_cnt_n;

  logic [NUM_REQ-1:0] w_pend, w_onehot;
  logic [IW-1:0]      w_pick;
  logic               w_any;
  logic [31:0]        w_pick_lba;
  logic               w_pick_wr;
  logic [7:0]         w_din;

  assign w_pend = bus.req_rd | bus.req_wr;

  // First pending index after the last owner, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    j      = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(r_last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_any && w_pend[j]) begin
        w_any  = 1'b1;
        w_pick = IW'(j);
      end
    end
  end

  always_comb begin
    w_onehot   = '0;
    w_pick_lba = '0;
    w_pick_wr  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IW'(i)) begin
        w_onehot[i] = 1'b1;
        w_pick_lba  = bus.req_lba[32*i +: 32];
        w_pick_wr   = bus.req_wr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_timeout <= '0;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_last    <= IW'(NUM_REQ - 1);
      r_sel     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_grant   <= w_grant_n;
      r_timeout <= w_timeout_n;
      r_lba     <= w_lba_n;
      r_rd      <= w_rd_n;
      r_wr      <= w_wr_n;
      r_last    <= w_last_n;
      r_sel     <= w_sel_n;
      r_cnt     <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_grant_n   = r_grant;
    w_timeout_n = '0;
    w_lba_n     = r_lba;
    w_rd_n      = r_rd;
    w_wr_n      = r_wr;
    w_last_n    = r_last;
    w_sel_n     = r_sel;
    w_cnt_n     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_sel_n   = w_pick;
          w_grant_n = w_onehot;
          w_lba_n   = w_pick_lba;
          // a requester holding both levels gets the write
          w_wr_n    = w_pick_wr;
          w_rd_n    = ~w_pick_wr;
          w_state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_n   = '0;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sd_ack) begin
          w_rd_n    = 1'b0;
          w_wr_n    = 1'b0;
          w_state_n = S_XFER;
        end else if (r_cnt == TIMEOUT - 24'd1) begin
          w_rd_n      = 1'b0;
          w_wr_n      = 1'b0;
          w_timeout_n = r_grant;
          w_grant_n   = '0;
          w_last_n    = r_sel;
          w_state_n   = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 24'd1;
        end
      end
      S_XFER: begin
        if (!bus.sd_ack) w_state_n = S_RELEASE;
      end
      S_RELEASE: begin
        w_grant_n = '0;
        w_last_n  = r_sel;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Requester buffers are registered RAMs on a broadcast address, so data is muxed combinationally.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_din = w_din | bus.req_buff_din[8*i +: 8];
    end
  end

  assign bus.req_ack     = {NUM_REQ{bus.sd_ack}} & r_grant;
  assign bus.req_buff_wr = {NUM_REQ{bus.sd_buff_wr}} & r_grant;
  assign bus.req_timeout = r_timeout;
  assign bus.grant       = r_grant;
  assign bus.sd_lba      = r_lba;
  assign bus.sd_rd       = r_rd;
  assign bus.sd_wr       = r_wr;
  assign bus.sd_buff_din = w_din;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: two requesters, TIMEOUT shortened to 16.
module tb_sd_req_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   steer_bad = 0;

  sd_req_arbiter_if #(.NUM_REQ(2)) bus();

  sd_req_arbiter #(.NUM_REQ(2), .TIMEOUT(24'd16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds sd_ack for len clocks, buff_wr on odd clocks; counts steering errors against eg.
  task automatic xfer(input int len, input logic [1:0] eg);
    logic [7:0] b, ed;
    logic [1:0] eb;
    for (int c = 0; c < len; c++) begin
      b = 8'(c);
      bus.req_buff_din = {b, ~b};
      bus.sd_ack       = 1'b1;
      bus.sd_buff_wr   = c[0];
      #1;
      ed = (eg == 2'b01) ? ~b : (eg == 2'b10) ? b : 8'h00;
      eb = c[0] ? eg : 2'b00;
      if (bus.req_ack !== eg || bus.req_buff_wr !== eb || bus.sd_buff_din !== ed)
        steer_bad++;
      tick();
    end
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", bus.grant); end
    checks++; if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL reset_sd_rd got %b exp 0", bus.sd_rd); end
    checks++; if (bus.sd_wr !== 1'b0) begin errors++; $display("FAIL reset_sd_wr got %b exp 0", bus.sd_wr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.sd_lba !== 32'h0) begin errors++; $display("FAIL reset_lba got %h exp 0", bus.sd_lba); end
    checks++; if (bus.req_timeout !== 2'b00) begin errors++; $display("FAIL reset_timeout got %b exp 00", bus.req_timeout); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    int blk[2] = '{0, 0};
    logic [1:0] exp;
    int w;
    steer_bad   = 0;
    bus.req_lba = {32'h0000_2000, 32'h0000_1000};
    bus.req_rd  = 2'b11;
    for (int n = 0; n < 8; n++) begin
      exp = n[0] ? 2'b10 : 2'b01;
      w = 0;
      while (bus.grant === 2'b00 && w < 10) begin tick(); w++; end
      checks++; if (bus.grant !== exp) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", n, bus.grant, exp); end
      tick();
      bus.req_rd = bus.req_rd & ~exp;
      xfer(8, exp);
      tick();
      blk[n[0]]++;
      if (blk[n[0]] < 4) bus.req_rd = bus.req_rd | exp;
      tick();
    end
    checks++; if (steer_bad !== 0) begin errors++; $display("FAIL cont_steer got %0d bad cycles exp 0", steer_bad); end
    bus.req_rd = 2'b00;
  endtask

  task automatic test_single();
    bus.req_lba = {32'h0, 32'h0000_0123};
    bus.req_rd  = 2'b01;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.grant); end
    checks++; if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0) begin errors++; $display("FAIL single_strobe got rd=%b wr=%b exp rd=1 wr=0", bus.sd_rd, bus.sd_wr); end
    checks++; if (bus.sd_lba !== 32'h123) begin errors++; $display("FAIL single_lba got %h exp 00000123", bus.sd_lba); end
    tick();
    bus.req_rd = 2'b00;
    steer_bad  = 0;
    xfer(512, 2'b01);
    checks++; if (steer_bad !== 0) begin errors++; $display("FAIL single_steer got %0d bad cycles exp 0", steer_bad); end
    checks++; if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL single_rd_drop got %b exp 0", bus.sd_rd); end
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.grant !== 2'b01) begin errors++; $display("FAIL single_release got busy=%b grant=%b exp busy=1 grant=01", bus.busy, bus.grant); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL single_idle got busy=%b grant=%b exp busy=0 grant=00", bus.busy, bus.grant); end
    checks++; if (bus.sd_lba !== 32'h123) begin errors++; $display("FAIL single_lba_hold got %h exp 00000123", bus.sd_lba); end
  endtask

  task automatic test_write();
    bus.req_lba = {32'h0000_ABCD, 32'h0};
    bus.req_wr  = 2'b10;
    bus.req_rd  = 2'b10;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL write_grant got %b exp 10", bus.grant); end
    checks++; if (bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0) begin errors++; $display("FAIL write_strobe got rd=%b wr=%b exp rd=0 wr=1", bus.sd_rd, bus.sd_wr); end
    checks++; if (bus.sd_lba !== 32'hABCD) begin errors++; $display("FAIL write_lba got %h exp 0000abcd", bus.sd_lba); end
    tick();
    bus.req_rd = 2'b00;
    bus.req_wr = 2'b00;
    steer_bad  = 0;
    xfer(16, 2'b10);
    checks++; if (steer_bad !== 0) begin errors++; $display("FAIL write_data got %0d bad cycles exp 0", steer_bad); end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bus.req_lba = {32'h0, 32'h0000_0055};
    bus.req_rd  = 2'b01;
    tick();
    checks++; if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1) begin errors++; $display("FAIL to_grant got grant=%b rd=%b exp grant=01 rd=1", bus.grant, bus.sd_rd); end
    tick();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.sd_rd !== 1'b1 || bus.req_timeout !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", bad); end
    tick();
    checks++; if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL to_rd_drop got %b exp 0", bus.sd_rd); end
    checks++; if (bus.req_timeout !== 2'b01) begin errors++; $display("FAIL to_pulse got %b exp 01", bus.req_timeout); end
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_idle got grant=%b busy=%b exp grant=00 busy=0", bus.grant, bus.busy); end
    tick();
    checks++; if (bus.req_timeout !== 2'b00) begin errors++; $display("FAIL to_pulse_end got %b exp 00", bus.req_timeout); end
    checks++; if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1) begin errors++; $display("FAIL to_regrant got grant=%b rd=%b exp grant=01 rd=1", bus.grant, bus.sd_rd); end
    tick();
    bus.req_rd = 2'b00;
    xfer(4, 2'b01);
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    bus.req_rd = 2'b01;
    tick();
    tick();
    bus.req_rd = 2'b00;
    steer_bad  = 0;
    xfer(2, 2'b01);
    bus.req_rd = 2'b10;
    xfer(1, 2'b01);
    bus.req_rd = 2'b00;
    xfer(2, 2'b01);
    checks++; if (steer_bad !== 0) begin errors++; $display("FAIL wd_steer got %0d bad cycles exp 0", steer_bad); end
    tick();
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL wd_never got grant=%b busy=%b exp grant=00 busy=0", bus.grant, bus.busy); end
    bus.sd_ack = 1'b1;
    #1;
    checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL idle_ack got %b exp 00", bus.req_ack); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL idle_ack_state got busy=%b grant=%b exp busy=0 grant=00", bus.busy, bus.grant); end
    bus.sd_ack = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.req_rd = 2'b01;
    tick();
    bus.sd_ack = 1'b1;
    bus.req_rd = 2'b00;
    tick();
    tick();
    checks++; if (bus.sd_rd !== 1'b0 || bus.busy !== 1'b1 || bus.req_ack !== 2'b01) begin errors++; $display("FAIL stale_ack got rd=%b busy=%b ack=%b exp rd=0 busy=1 ack=01", bus.sd_rd, bus.busy, bus.req_ack); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_state got grant=%b busy=%b exp grant=00 busy=0", bus.grant, bus.busy); end
    checks++; if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin errors++; $display("FAIL arst_strobe got rd=%b wr=%b exp 0 0", bus.sd_rd, bus.sd_wr); end
    checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL arst_ack got %b exp 00", bus.req_ack); end
    bus.sd_ack = 1'b0;
    #4 reset_n = 1'b1;
    @(negedge clk);
    bus.req_rd = 2'b11;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL arst_first got %b exp 01", bus.grant); end
    bus.req_rd = 2'b00;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.req_lba      = '0;
    bus.req_rd       = '0;
    bus.req_wr       = '0;
    bus.req_buff_din = '0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_wr   = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_write();
    test_timeout();
    test_withdraw();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
